ppu_oam_dma: RTL and testbench
==============================

# ppu_oam_dma

Sequencer and arbiter for the PPU's 256-byte sprite RAM (OAM). It owns the sprite RAM address/data/write port and shares it between two requesters:
- CPU register accesses ($2003 OAMADDR, $2004 OAMDATA);
- the $4014 OAM DMA engine, which halts the CPU and copies one 256-byte CPU-memory page into sprite RAM.

It sits between the CPU bus decode and the sprite RAM.

## Interface
- DUMMY_CYCLES, 1, number of halt cycles between the DMA request and the first memory read (range 1..3).

- clk_in  in  1  system clock (50 MHz).
- rst_in  in  1  reset: synchronous, active-low; sampled on the rising edge of clk_in.
- dma_req_in  in  1  one-cycle pulse: CPU wrote $4014.
- dma_page_in  in  8  source page (high address byte), valid with dma_req_in.
- oamaddr_wr_in  in  1  one-cycle pulse: CPU write to $2003.
- oamdata_wr_in  in  1  one-cycle pulse: CPU write to $2004.
- cpu_d_in  in  8  CPU write data for $2003/$2004.
- mem_d_in  in  8  CPU-memory read data, valid the cycle after mem_rd_out.
- cpu_rdy_out  out  1  1 = CPU may run; 0 = CPU halted by DMA.
- busy_out  out  1  DMA in progress.
- mem_a_out  out  16  CPU-memory read address.
- mem_rd_out  out  1  CPU-memory read strobe.
- spr_ram_a_out  out  8  sprite RAM address.
- spr_ram_d_out  out  8  sprite RAM write data.
- spr_ram_wr_out  out  1  sprite RAM write enable.
- oamaddr_out  out  8  current OAMADDR (feeds the $2004 read path).

## Operation
- States: IDLE, HALT, READ, WRITE. Registers:
  - oamaddr[7:0];
  - page[7:0];
  - 8-bit byte index idx;
  - 2-bit halt counter.
- IDLE: sprite RAM port belongs to the CPU.
  - spr_ram_a_out = oamaddr; spr_ram_d_out = cpu_d_in; spr_ram_wr_out = oamdata_wr_in (combinational).
  - oamaddr_wr_in: oamaddr <= cpu_d_in.
  - oamdata_wr_in: write at oamaddr, then oamaddr <= oamaddr+1 (mod 256).
  - oamaddr_wr_in and oamdata_wr_in in the same cycle: the address load wins, spr_ram_wr_out is forced 0, and there is no increment.
  - dma_req_in: page <= dma_page_in, idx <= 0, halt counter <= 0, go to HALT.
  - dma_req_in with oamdata_wr_in in the same cycle: the data write completes (including the increment), then the DMA starts from the incremented oamaddr.
- HALT: cpu_rdy_out = 0. Stay for DUMMY_CYCLES cycles, then go to READ.
- READ: mem_rd_out = 1; mem_a_out = {page, idx}; spr_ram_wr_out = 0. Go to WRITE.
- WRITE:
  - spr_ram_a_out = oamaddr+idx (mod 256); spr_ram_d_out = mem_d_in; spr_ram_wr_out = 1.
  - idx = 255: go to IDLE. Otherwise idx <= idx+1 and go to READ.
- oamaddr is unchanged across a full DMA: the 256 writes wrap the address back to its start value.
- While busy: dma_req_in, oamaddr_wr_in and oamdata_wr_in are ignored. There is no restart and no register change.
- Outside READ: mem_rd_out = 0 and mem_a_out holds its last value.
- Arithmetic: all 8-bit address math wraps modulo 256; mem_a_out never crosses a page.

## Timing
- Reset values:
  - state IDLE;
  - cpu_rdy_out 1, busy_out 0;
  - mem_rd_out 0, mem_a_out 0x0000;
  - spr_ram_wr_out 0, spr_ram_a_out 0x00;
  - oamaddr_out 0x00; idx, page and halt counter 0.
- Reset asserted mid-DMA: next edge returns to IDLE with the reset values above. The transfer is abandoned; bytes already written stay written.
- DMA request sampled at edge T:
  - cpu_rdy_out and busy_out go 0 after edge T (registered);
  - first READ cycle follows edge T+DUMMY_CYCLES;
  - byte k: READ after edge T+DUMMY_CYCLES+2k, WRITE after edge T+DUMMY_CYCLES+2k+1;
  - cpu_rdy_out and busy_out return to 1/0 after edge T+DUMMY_CYCLES+512.
- Total CPU halt: DUMMY_CYCLES+512 cycles.
- Memory latency is fixed at 1 cycle; there is no wait-state handshake.
- CPU writes in IDLE take effect in the same cycle (RAM write) or at the next edge (oamaddr).

## Test plan
- Reset, then $2003 write 0x10 followed by $2004 writes 0xAA and 0xBB: RAM[0x10]=0xAA, RAM[0x11]=0xBB, oamaddr_out=0x12.
- Memory page 0x02 preloaded with byte i = i^0x5A, oamaddr=0, DMA with page 0x02 and DUMMY_CYCLES=1:
  - RAM[i]=i^0x5A for all i;
  - cpu_rdy_out low for exactly 513 cycles;
  - mem_a_out runs 0x0200..0x02FF.
- oamaddr=0xF0, DMA with page 0x03: byte k lands at (0xF0+k) mod 256, so byte 0x10 is at RAM[0x00]; oamaddr_out=0xF0 afterwards.
- Second dma_req_in and a $2004 write injected mid-DMA: both ignored; RAM contents and the DMA cycle count are unchanged.
- rst_in low at byte 100 of a DMA:
  - next cycle cpu_rdy_out=1, busy_out=0, oamaddr_out=0;
  - RAM[0..99] hold DMA data; RAM[100..255] are untouched.
- Same-cycle events:
  - oamaddr_wr_in with oamdata_wr_in (cpu_d_in=0x40): oamaddr=0x40 and no RAM write;
  - dma_req_in with oamdata_wr_in: data written at the old oamaddr, then the DMA starts at oamaddr+1.

Source files
------------

// File: rtl/ppu_oam_dma.sv
// rtl/ppu_oam_dma.sv - sprite RAM port arbiter and $4014 OAM DMA sequencer
// CPU register writes own the sprite RAM port in IDLE; DMA owns it otherwise.
module ppu_oam_dma #(
   parameter int DUMMY_CYCLES = 1
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        dma_req_in,
   input  logic [7:0]  dma_page_in,
   input  logic        oamaddr_wr_in,
   input  logic        oamdata_wr_in,
   input  logic [7:0]  cpu_d_in,
   input  logic [7:0]  mem_d_in,
   output logic        cpu_rdy_out,
   output logic        busy_out,
   output logic [15:0] mem_a_out,
   output logic        mem_rd_out,
   output logic [7:0]  spr_ram_a_out,
   output logic [7:0]  spr_ram_d_out,
   output logic        spr_ram_wr_out,
   output logic [7:0]  oamaddr_out
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_HALT  = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_WRITE = 2'd3;

   localparam logic [1:0] HALT_LAST = 2'(DUMMY_CYCLES - 1);

   logic [1:0]  state;
   logic [7:0]  oamaddr;
   logic [7:0]  page;
   logic [7:0]  idx;
   logic [1:0]  halt_cnt;
   logic [15:0] mem_a_q;
   logic [7:0]  dma_a;

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state    <= S_IDLE;
         oamaddr  <= 8'h00;
         page     <= 8'h00;
         idx      <= 8'h00;
         halt_cnt <= 2'd0;
         mem_a_q  <= 16'h0000;
      end else begin
         case (state)
            S_IDLE: begin
               // Address load beats the data-write increment when both arrive together.
               if (oamaddr_wr_in)
                  oamaddr <= cpu_d_in;
               else if (oamdata_wr_in)
                  oamaddr <= oamaddr + 8'd1;
               if (dma_req_in) begin
                  page     <= dma_page_in;
                  idx      <= 8'h00;
                  halt_cnt <= 2'd0;
                  state    <= S_HALT;
               end
            end
            S_HALT: begin
               if (halt_cnt == HALT_LAST)
                  state <= S_READ;
               else
                  halt_cnt <= halt_cnt + 2'd1;
            end
            S_READ: begin
               mem_a_q <= {page, idx};
               state   <= S_WRITE;
            end
            S_WRITE: begin
               if (idx == 8'hFF) begin
                  state <= S_IDLE;
               end else begin
                  idx   <= idx + 8'd1;
                  state <= S_READ;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // 256 writes starting at oamaddr wrap back around, so oamaddr itself never moves.
   assign dma_a = oamaddr + idx;

   assign cpu_rdy_out    = (state == S_IDLE);
   assign busy_out       = (state != S_IDLE);
   assign mem_rd_out     = (state == S_READ);
   assign mem_a_out      = (state == S_READ) ? {page, idx} : mem_a_q;
   assign spr_ram_a_out  = (state == S_IDLE) ? oamaddr : dma_a;
   assign spr_ram_d_out  = (state == S_IDLE) ? cpu_d_in : mem_d_in;
   assign spr_ram_wr_out = (state == S_IDLE) ? (oamdata_wr_in & ~oamaddr_wr_in)
                                             : (state == S_WRITE);
   assign oamaddr_out    = oamaddr;

endmodule

// File: tb/tb_ppu_oam_dma.sv
// tb/tb_ppu_oam_dma.sv - directed bench for ppu_oam_dma with memory and sprite RAM models
module tb_ppu_oam_dma;

   logic        clk = 1'b0;
   logic        rst_in = 1'b0;
   logic        dma_req_in = 1'b0;
   logic [7:0]  dma_page_in = 8'h00;
   logic        oamaddr_wr_in = 1'b0;
   logic        oamdata_wr_in = 1'b0;
   logic [7:0]  cpu_d_in = 8'h00;
   logic [7:0]  mem_d_in = 8'h00;
   logic        cpu_rdy_out, busy_out, mem_rd_out, spr_ram_wr_out;
   logic [15:0] mem_a_out;
   logic [7:0]  spr_ram_a_out, spr_ram_d_out, oamaddr_out;

   logic [7:0]  ram [0:255];
   logic        ram_clr = 1'b0;

   int total = 0;
   int bad = 0;

   always #10 clk = ~clk;

   ppu_oam_dma #(.DUMMY_CYCLES(1)) dut (
      .clk_in(clk), .rst_in(rst_in), .dma_req_in(dma_req_in), .dma_page_in(dma_page_in),
      .oamaddr_wr_in(oamaddr_wr_in), .oamdata_wr_in(oamdata_wr_in), .cpu_d_in(cpu_d_in),
      .mem_d_in(mem_d_in), .cpu_rdy_out(cpu_rdy_out), .busy_out(busy_out),
      .mem_a_out(mem_a_out), .mem_rd_out(mem_rd_out), .spr_ram_a_out(spr_ram_a_out),
      .spr_ram_d_out(spr_ram_d_out), .spr_ram_wr_out(spr_ram_wr_out), .oamaddr_out(oamaddr_out)
   );

   function automatic logic [7:0] mdat(input logic [7:0] p, input logic [7:0] i);
      return (p == 8'h02) ? (i ^ 8'h5A) : (i ^ 8'hC3);
   endfunction

   // CPU memory with one cycle read latency, and the sprite RAM itself
   always @(posedge clk) begin
      if (mem_rd_out) mem_d_in <= mdat(mem_a_out[15:8], mem_a_out[7:0]);
   end

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'hEE;
      end else if (spr_ram_wr_out) begin
         ram[spr_ram_a_out] <= spr_ram_d_out;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic cpu_wr(input logic aw, input logic dw, input logic [7:0] d);
      @(posedge clk); #1;
      oamaddr_wr_in = aw; oamdata_wr_in = dw; cpu_d_in = d;
      @(posedge clk); #1;
      oamaddr_wr_in = 1'b0; oamdata_wr_in = 1'b0;
   endtask

   task automatic clear_ram();
      @(posedge clk); #1 ram_clr = 1'b1;
      @(posedge clk); #1 ram_clr = 1'b0;
   endtask

   // Runs one DMA, counting halted cycles and checking the read address sequence.
   task automatic run_dma(input logic [7:0] p, input int inj, input int rst_byte,
                          input logic with_wr, input logic [7:0] wr_d,
                          output int halt, output int rd_bad);
      int k;
      halt = 0; rd_bad = 0; k = 0;
      @(posedge clk); #1;
      dma_req_in = 1'b1; dma_page_in = p;
      if (with_wr) begin
         oamdata_wr_in = 1'b1; cpu_d_in = wr_d;
         @(negedge clk);
         chk("samecyc_wr", {31'd0, spr_ram_wr_out}, 32'd1);
         chk("samecyc_a", {24'd0, spr_ram_a_out}, 32'h20);
         chk("samecyc_d", {24'd0, spr_ram_d_out}, {24'd0, wr_d});
      end
      @(posedge clk); #1;
      dma_req_in = 1'b0; oamdata_wr_in = 1'b0;
      for (int n = 0; n < 1200; n++) begin
         @(negedge clk);
         if (cpu_rdy_out) break;
         halt++;
         if (mem_rd_out) begin
            if (mem_a_out !== {p, 8'(k)}) rd_bad++;
            if (k == rst_byte) rst_in = 1'b0;
            k++;
         end else if (k > 0 && mem_a_out !== {p, 8'(k - 1)}) begin
            rd_bad++;
         end
         if (n == inj) begin
            dma_req_in = 1'b1; dma_page_in = 8'h07; oamdata_wr_in = 1'b1; cpu_d_in = 8'h99;
         end else if (n == inj + 1) begin
            dma_req_in = 1'b0; oamdata_wr_in = 1'b0; oamaddr_wr_in = 1'b1;
         end else if (n == inj + 2) begin
            oamaddr_wr_in = 1'b0;
         end
      end
      if (rst_byte < 0) chk("dma_reads", k, 256);
   endtask

   typedef struct {
      logic       aw;
      logic       dw;
      logic [7:0] d;
      logic       exp_wr;
      logic [7:0] exp_a;
      logic [7:0] exp_oam;
   } vec_t;

   vec_t vec [6];

   initial begin
      int halt, rd_bad, errs;

      vec[0] = '{1'b1, 1'b0, 8'h10, 1'b0, 8'h00, 8'h10};
      vec[1] = '{1'b0, 1'b1, 8'hAA, 1'b1, 8'h10, 8'h11};
      vec[2] = '{1'b0, 1'b1, 8'hBB, 1'b1, 8'h11, 8'h12};
      vec[3] = '{1'b1, 1'b1, 8'h40, 1'b0, 8'h12, 8'h40};
      vec[4] = '{1'b1, 1'b0, 8'hFF, 1'b0, 8'h40, 8'hFF};
      vec[5] = '{1'b0, 1'b1, 8'h77, 1'b1, 8'hFF, 8'h00};

      repeat (3) @(posedge clk);
      #1 rst_in = 1'b1;
      @(negedge clk);
      chk("rst_cpu_rdy", {31'd0, cpu_rdy_out}, 32'd1);
      chk("rst_busy", {31'd0, busy_out}, 32'd0);
      chk("rst_mem_rd", {31'd0, mem_rd_out}, 32'd0);
      chk("rst_mem_a", {16'd0, mem_a_out}, 32'h0000);
      chk("rst_spr_wr", {31'd0, spr_ram_wr_out}, 32'd0);
      chk("rst_spr_a", {24'd0, spr_ram_a_out}, 32'h00);
      chk("rst_oamaddr", {24'd0, oamaddr_out}, 32'h00);

      clear_ram();
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         oamaddr_wr_in = vec[i].aw; oamdata_wr_in = vec[i].dw; cpu_d_in = vec[i].d;
         @(negedge clk);
         chk($sformatf("vec%0d_wr", i), {31'd0, spr_ram_wr_out}, {31'd0, vec[i].exp_wr});
         chk($sformatf("vec%0d_a", i), {24'd0, spr_ram_a_out}, {24'd0, vec[i].exp_a});
         @(posedge clk); #1;
         oamaddr_wr_in = 1'b0; oamdata_wr_in = 1'b0;
         chk($sformatf("vec%0d_oam", i), {24'd0, oamaddr_out}, {24'd0, vec[i].exp_oam});
      end
      chk("ram_10", {24'd0, ram[8'h10]}, 32'hAA);
      chk("ram_11", {24'd0, ram[8'h11]}, 32'hBB);
      chk("ram_ff", {24'd0, ram[8'hFF]}, 32'h77);
      chk("ram_40_untouched", {24'd0, ram[8'h40]}, 32'hEE);

      // full DMA from page 2 to oamaddr 0
      clear_ram();
      cpu_wr(1'b1, 1'b0, 8'h00);
      run_dma(8'h02, 100000, -1, 1'b0, 8'h00, halt, rd_bad);
      chk("dma1_halt", halt, 513);
      chk("dma1_mem_a", rd_bad, 0);
      errs = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== (8'(i) ^ 8'h5A)) errs++;
      chk("dma1_ram", errs, 0);
      chk("dma1_oamaddr", {24'd0, oamaddr_out}, 32'h00);

      // offset DMA wraps the sprite RAM address
      clear_ram();
      cpu_wr(1'b1, 1'b0, 8'hF0);
      run_dma(8'h03, 100000, -1, 1'b0, 8'h00, halt, rd_bad);
      chk("dma2_halt", halt, 513);
      chk("dma2_mem_a", rd_bad, 0);
      errs = 0;
      for (int k = 0; k < 256; k++) if (ram[8'(8'hF0 + k)] !== (8'(k) ^ 8'hC3)) errs++;
      chk("dma2_ram", errs, 0);
      chk("dma2_ram00", {24'd0, ram[8'h00]}, {24'd0, 8'h10 ^ 8'hC3});
      chk("dma2_oamaddr", {24'd0, oamaddr_out}, 32'hF0);

      // requests and register writes injected mid-DMA are ignored
      clear_ram();
      cpu_wr(1'b1, 1'b0, 8'h00);
      run_dma(8'h02, 50, -1, 1'b0, 8'h00, halt, rd_bad);
      chk("inj_halt", halt, 513);
      chk("inj_mem_a", rd_bad, 0);
      errs = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== (8'(i) ^ 8'h5A)) errs++;
      chk("inj_ram", errs, 0);
      chk("inj_oamaddr", {24'd0, oamaddr_out}, 32'h00);

      // DMA request in the same cycle as a $2004 write
      clear_ram();
      cpu_wr(1'b1, 1'b0, 8'h20);
      run_dma(8'h03, 100000, -1, 1'b1, 8'h33, halt, rd_bad);
      chk("samecyc_halt", halt, 513);
      chk("samecyc_ram21", {24'd0, ram[8'h21]}, {24'd0, 8'h00 ^ 8'hC3});
      chk("samecyc_ram20", {24'd0, ram[8'h20]}, {24'd0, 8'hFF ^ 8'hC3});
      chk("samecyc_oamaddr", {24'd0, oamaddr_out}, 32'h21);

      // reset during byte 100
      clear_ram();
      cpu_wr(1'b1, 1'b0, 8'h00);
      run_dma(8'h02, 100000, 100, 1'b0, 8'h00, halt, rd_bad);
      chk("rstmid_bound", {31'd0, halt < 1200}, 32'd1);
      chk("rstmid_cpu_rdy", {31'd0, cpu_rdy_out}, 32'd1);
      chk("rstmid_busy", {31'd0, busy_out}, 32'd0);
      chk("rstmid_oamaddr", {24'd0, oamaddr_out}, 32'h00);
      chk("rstmid_mem_rd", {31'd0, mem_rd_out}, 32'd0);
      #1 rst_in = 1'b1;
      errs = 0;
      for (int i = 0; i < 100; i++) if (ram[i] !== (8'(i) ^ 8'h5A)) errs++;
      chk("rstmid_ram_done", errs, 0);
      errs = 0;
      for (int i = 100; i < 256; i++) if (ram[i] !== 8'hEE) errs++;
      chk("rstmid_ram_untouched", errs, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
